// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//
// Shared definitions for the mux scan controller: the controller state
// encoding, channel/index/counter widths and a small parity helper.
// Imported by mux_scan_settle_cnt and mux_scan_ctrl.
package mux_scan_pkg;

    localparam int NUM_CH = 8;   // number of mux inputs scanned per word
    localparam int IDX_W  = 3;   // width of the select index
    localparam int CNT_W  = 4;   // width of the settle counter (0..15)

    // Index of the final channel; sampling it ends the scan.
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Even parity bit: 1 when the word has an odd number of ones, so that
    // word plus parity always carries an even count.
    function automatic logic even_parity(input logic [NUM_CH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// mux_scan_settle_cnt
//
// Per-select settle timer. While en is high it counts 0..SETTLE_CYCLES and
// raises tc_o in the cycle the count equals SETTLE_CYCLES; on that cycle it
// wraps back to 0 so the next select window starts fresh. clr forces the
// count to 0 (used whenever the controller is not scanning).
//
// Parameters:
//   SETTLE_CYCLES  extra wait cycles per select value (0..15)
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   en     count enable
//   clr    synchronous clear (priority over en)
//   tc_o   terminal count: sample point of the current select window
module mux_scan_settle_cnt
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 0
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign tc_o    = en & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//
// Scan controller for an external 8x1 single-bit mux. On start it steps the
// select lines through 0..7, samples mux_in once per select (in the last
// cycle of each settle window), assembles the samples into a byte and
// offers it downstream on a valid/ready handshake.
//
// Optional feature macro: MUX_SCAN_PARITY_EN
//   defined   -> parity_o port present, equal to ^data_o, registered with it
//   undefined -> parity_o port and its logic are absent
//
// Parameters:
//   SETTLE_CYCLES  extra wait cycles per select value before sampling (0..15)
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     scan request, only honoured in IDLE (or on a HOLD transfer)
//   busy      high in SCAN and HOLD
//   sel0..2   mux select, {sel2,sel1,sel0} = current index while scanning
//   mux_in    mux output being scanned
//   data_o    assembled word, data_o[k] = sample taken with select k
//   valid_o   data_o valid
//   parity_o  even parity of data_o (MUX_SCAN_PARITY_EN only)
//   ready_i   downstream accepts data_o
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              sel0,
    output logic              sel1,
    output logic              sel2,
    input  logic              mux_in,
    output logic [NUM_CH-1:0] data_o,
    output logic              valid_o,
`ifdef MUX_SCAN_PARITY_EN
    output logic              parity_o,
`endif
    input  logic              ready_i
);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [NUM_CH-1:0] shadow_q;
    logic [NUM_CH-1:0] shadow_d;
    logic [NUM_CH-1:0] shadow_we;
    logic [NUM_CH-1:0] data_q;
    logic [NUM_CH-1:0] data_d;
    logic              valid_q;
    logic              valid_d;

    logic              scanning;
    logic              settle_tc;
    logic              sample_now;
    logic              xfer;
    logic [IDX_W-1:0]  sel_vec;

    assign scanning   = (state_q == SCAN);
    assign sample_now = scanning & settle_tc;
    assign xfer       = valid_q & ready_i;

    // Counter is held at zero outside SCAN so every scan begins with a full
    // settle window on select 0.
    mux_scan_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (scanning),
        .clr  (~scanning),
        .tc_o (settle_tc)
    );

    // Per-channel shadow write: bit gi captures mux_in on the sample point
    // of select window gi and otherwise keeps its value.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shadow
            assign shadow_we[gi] = sample_now && (idx_q == IDX_W'(gi));
            assign shadow_d[gi]  = shadow_we[gi] ? mux_in : shadow_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end

            SCAN: begin
                if (sample_now) begin
                    if (idx_q == IDX_LAST) begin
                        // shadow_d already holds the final sample, so the
                        // word is published on the same edge that enters HOLD.
                        state_d = HOLD;
                        idx_d   = '0;
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            HOLD: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    // start in the transfer cycle chains straight into a
                    // new scan with no idle bubble.
                    state_d = start ? SCAN : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Selects follow the index only while scanning; IDLE and HOLD park at 0.
    assign sel_vec = scanning ? idx_q : '0;
    assign sel0    = sel_vec[0];
    assign sel1    = sel_vec[1];
    assign sel2    = sel_vec[2];

    assign busy    = (state_q != IDLE);
    assign data_o  = data_q;
    assign valid_o = valid_q;

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Derived from data_d so parity updates on exactly the edge data_o does.
    assign parity_d = even_parity(data_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule
